// File: rtl/dcache_resp.sv
// rtl/dcache_resp.sv - data-side responder: direct-mapped write-through load cache with req/ack backing memory
//
// Purpose: serves loads from a direct-mapped, write-through, no-write-allocate
// cache of one-word lines; load misses and every store go to a word-wide backing
// memory over a req/ack handshake while stall freezes the upstream pipeline.
//
// Ports:
//   clk, rst                 rising-edge clock, asynchronous active-high reset
//   memread, memwrite        load / store request (store wins when both set)
//   length, sign             access size (00 byte, 01 half, 1x word), load sign-extend
//   addr, wdata              byte address (only [AW-1:0] used), right-justified store data
//   rdata, cachehit, stall   load result, same-cycle hit flag, pipeline freeze
//   mem_req, mem_we          backing-memory request (held until ack), write select
//   mem_addr, mem_wdata      word-aligned address, lane-replicated store data
//   mem_be                   byte enables (1111 for reads)
//   mem_ack, mem_rdata       one-cycle completion pulse, read word valid with ack
//   hit_count, miss_count    saturating statistics, present only with DCACHE_STATS_EN
//
// Optional feature macro: DCACHE_STATS_EN
module dcache_resp #(
  parameter int LINES = 16,
  parameter int AW    = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          memread,
  input  logic          memwrite,
  input  logic [1:0]    length,
  input  logic          sign,
  input  logic [31:0]   addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata,
  output logic          cachehit,
  output logic          stall,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic [3:0]    mem_be,
  input  logic          mem_ack,
  input  logic [31:0]   mem_rdata
`ifdef DCACHE_STATS_EN
  ,
  output logic [15:0]   hit_count,
  output logic [15:0]   miss_count
`endif
);

  localparam int IW = $clog2(LINES);
  localparam int TW = AW - 2 - IW;

  typedef enum logic [1:0] {IDLE, MISS, WRITE, DONE} state_t;

  state_t state, state_nx;

  logic [LINES-1:0] valid_q;
  logic [TW-1:0]    tag_q  [LINES];
  logic [31:0]      data_q [LINES];

  logic [31:0] resp_q;
  logic [1:0]  cap_off;
  logic [1:0]  cap_len;
  logic        cap_sign;

  logic [IW-1:0] idx, m_idx;
  logic [TW-1:0] tag, m_tag;
  logic          hit, m_hit;
  logic          store_go, load_hit, load_miss;
  logic [3:0]    st_be;
  logic [31:0]   st_wdata;
  logic [AW-1:0] word_addr;
  logic          unused_addr;

  assign unused_addr = ^addr[31:AW];

  function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] off,
                                          input logic [1:0] len, input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> {off, 3'b000});
    h = off[1] ? w[31:16] : w[15:0];
    case (len)
      2'b00:   return {{24{sgn & b[7]}}, b};
      2'b01:   return {{16{sgn & h[15]}}, h};
      default: return w;
    endcase
  endfunction

  assign idx       = addr[2 +: IW];
  assign tag       = addr[AW-1:2+IW];
  assign hit       = valid_q[idx] && (tag_q[idx] == tag);
  assign word_addr = {addr[AW-1:2], 2'b00};

  // The outstanding line is addressed from the registered mem_addr, not addr.
  assign m_idx = mem_addr[2 +: IW];
  assign m_tag = mem_addr[AW-1:2+IW];
  assign m_hit = valid_q[m_idx] && (tag_q[m_idx] == m_tag);

  assign store_go  = (state == IDLE) && memwrite;
  assign load_hit  = (state == IDLE) && !memwrite && memread && hit;
  assign load_miss = (state == IDLE) && !memwrite && memread && !hit;

  always_comb begin
    st_be    = 4'b1111;
    st_wdata = wdata;
    case (length)
      2'b00: begin
        st_be    = 4'b0001 << addr[1:0];
        st_wdata = {4{wdata[7:0]}};
      end
      2'b01: begin
        st_be    = addr[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Outputs are forced quiet while rst is high so stall/req drop the moment
  // reset asserts, even with a request still presented.
  always_comb begin
    state_nx = state;
    stall    = 1'b0;
    cachehit = 1'b0;
    rdata    = '0;
    mem_req  = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (memwrite) begin
            stall    = 1'b1;
            state_nx = WRITE;
          end else if (memread) begin
            if (hit) begin
              cachehit = 1'b1;
              rdata    = extract(data_q[idx], addr[1:0], length, sign);
            end else begin
              stall    = 1'b1;
              state_nx = MISS;
            end
          end
        end
        MISS, WRITE: begin
          stall   = 1'b1;
          mem_req = 1'b1;
          if (mem_ack) state_nx = DONE;
        end
        DONE: begin
          rdata    = resp_q;
          state_nx = IDLE;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      resp_q    <= '0;
      cap_off   <= '0;
      cap_len   <= '0;
      cap_sign  <= 1'b0;
    end else begin
      if (store_go) begin
        mem_we    <= 1'b1;
        mem_addr  <= word_addr;
        mem_be    <= st_be;
        mem_wdata <= st_wdata;
        resp_q    <= '0;
      end else if (load_miss) begin
        mem_we    <= 1'b0;
        mem_addr  <= word_addr;
        mem_be    <= 4'b1111;
        mem_wdata <= '0;
        cap_off   <= addr[1:0];
        cap_len   <= length;
        cap_sign  <= sign;
      end
      if (state == MISS && mem_ack) begin
        valid_q[m_idx] <= 1'b1;
        resp_q         <= extract(mem_rdata, cap_off, cap_len, cap_sign);
      end
    end
  end

  // Tag/data arrays need no reset: valid_q alone qualifies them.
  always_ff @(posedge clk) begin
    if (state == MISS && mem_ack) begin
      tag_q[m_idx]  <= m_tag;
      data_q[m_idx] <= mem_rdata;
    end else if (state == WRITE && mem_ack && m_hit) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_be[i]) data_q[m_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
    end
  end

`ifdef DCACHE_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (load_hit && hit_count != 16'hFFFF)   hit_count  <= hit_count + 16'd1;
      if (load_miss && miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_resp.sv
// tb/tb_dcache_resp.sv - randomized self-checking bench for dcache_resp against a behavioural model
module tb_dcache_resp;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          memread, memwrite, sign;
  logic [1:0]    length;
  logic [31:0]   addr, wdata;
  logic [31:0]   rdata;
  logic          cachehit, stall, mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_be;
  logic          mem_ack;
  logic [31:0]   mem_rdata;
`ifdef DCACHE_STATS_EN
  logic [15:0]   hc, mc;
`endif

  always #5 clk = ~clk;

  dcache_resp #(.LINES(16), .AW(AW)) dut (
    .clk(clk), .rst(rst), .memread(memread), .memwrite(memwrite),
    .length(length), .sign(sign), .addr(addr), .wdata(wdata),
    .rdata(rdata), .cachehit(cachehit), .stall(stall), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
`ifdef DCACHE_STATS_EN
    , .hit_count(hc), .miss_count(mc)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Model: backing memory (word-indexed) plus which tag each line holds.
  logic [31:0] bmem [1024];
  bit          mvalid [16];
  logic [5:0]  mtag [16];

  bit          chk_en = 0, chk_rd = 0, chk_bus = 0;
  logic        exp_stall, exp_hit, exp_req, exp_we;
  logic [31:0] exp_rdata, exp_wdata;
  logic [31:0] exp_addr;
  logic [3:0]  exp_be;
  logic [3:0]  obs_be;
  logic [31:0] obs_wd;
  logic        obs_we;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ext(input logic [31:0] w, input logic [1:0] off,
                                      input logic [1:0] len, input bit sg);
    logic [31:0] v;
    case (len)
      2'd0: begin
        v = (w >> (8 * off)) & 32'hFF;
        if (sg && v[7]) v = v | 32'hFFFFFF00;
      end
      2'd1: begin
        v = (w >> (off[1] ? 16 : 0)) & 32'hFFFF;
        if (sg && v[15]) v = v | 32'hFFFF0000;
      end
      default: v = w;
    endcase
    return v;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall", {31'b0, stall}, {31'b0, exp_stall});
      chk("cachehit", {31'b0, cachehit}, {31'b0, exp_hit});
      chk("mem_req", {31'b0, mem_req}, {31'b0, exp_req});
      if (chk_rd) chk("rdata", rdata, exp_rdata);
      if (chk_bus) begin
        chk("mem_we", {31'b0, mem_we}, {31'b0, exp_we});
        chk("mem_addr", 32'(mem_addr), exp_addr);
        chk("mem_be", {28'b0, mem_be}, {28'b0, exp_be});
        if (exp_we) chk("mem_wdata", mem_wdata, exp_wdata);
      end
    end
  end

  // One complete pipeline request, from presentation until the pipeline advances.
  task automatic op(input bit rd, input bit wr, input logic [1:0] len, input bit sg,
                    input logic [31:0] a, input logic [31:0] wd, input int dly,
                    output logic [31:0] got, output int nstall, output int nreq);
    int          wi, idx;
    logic [5:0]  tg;
    bit          hit;
    logic [3:0]  be;
    logic [31:0] lw;
    wi = int'(a[11:2]);
    idx = int'(a[5:2]);
    tg = a[11:6];
    hit = mvalid[idx] && (mtag[idx] == tg);
    memread = rd; memwrite = wr; length = len; sign = sg; addr = a; wdata = wd;
    got = 0; nstall = 0; nreq = 0;
    chk_bus = 0; exp_req = 0; exp_hit = 0;
    case (len)
      2'd0: begin be = 4'b0001 << a[1:0]; lw = {4{wd[7:0]}}; end
      2'd1: begin be = a[1] ? 4'b1100 : 4'b0011; lw = {2{wd[15:0]}}; end
      default: begin be = 4'b1111; lw = wd; end
    endcase
    if (!rd && !wr) begin
      exp_stall = 0; exp_rdata = 0; chk_rd = 1;
      @(negedge clk);
      @(posedge clk); #1;
      return;
    end
    if (!wr && hit) begin
      exp_stall = 0; exp_hit = 1; chk_rd = 1;
      exp_rdata = ext(bmem[wi], a[1:0], len, sg);
      @(negedge clk); got = rdata;
      @(posedge clk); #1;
      memread = 0;
      return;
    end
    exp_stall = 1; chk_rd = 0;
    @(negedge clk); nstall += int'(stall);
    @(posedge clk); #1;
    exp_req = 1; exp_we = wr; exp_addr = {20'b0, a[11:2], 2'b00};
    exp_be = wr ? be : 4'b1111; exp_wdata = lw; chk_bus = 1;
    for (int c = 0; c <= dly; c++) begin
      if (c == dly) begin
        mem_ack = 1;
        mem_rdata = wr ? $urandom() : bmem[wi];
      end
      @(negedge clk);
      nstall += int'(stall); nreq += int'(mem_req);
      obs_be = mem_be; obs_wd = mem_wdata; obs_we = mem_we;
      @(posedge clk); #1;
      mem_ack = 0;
    end
    chk_bus = 0; exp_req = 0; exp_stall = 0;
    if (wr) begin
      for (int b = 0; b < 4; b++) if (be[b]) bmem[wi][8*b +: 8] = lw[8*b +: 8];
      chk_rd = 0;
    end else begin
      mvalid[idx] = 1; mtag[idx] = tg;
      exp_rdata = ext(bmem[wi], a[1:0], len, sg); chk_rd = 1;
    end
    @(negedge clk); got = rdata; nstall += int'(stall);
    @(posedge clk); #1;
    memread = 0; memwrite = 0;
  endtask

  logic [31:0] got, r;
  int          ns, nr;

  initial begin
    rst = 1; memread = 0; memwrite = 0; length = 0; sign = 0; addr = 0; wdata = 0;
    mem_ack = 0; mem_rdata = 0;
    for (int i = 0; i < 1024; i++) bmem[i] = $urandom();
    for (int i = 0; i < 16; i++) begin mvalid[i] = 0; mtag[i] = 0; end
    bmem[16] = 32'hDEADBEEF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_req", {31'b0, mem_req}, 32'd0);
    chk("rst_we", {31'b0, mem_we}, 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_be", {28'b0, mem_be}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    @(posedge clk); #1; rst = 0;
    chk_en = 1;

    op(1, 0, 2'b10, 0, 32'h040, 0, 2, got, ns, nr);
    chk("miss_rdata", got, 32'hDEADBEEF);
    chk("miss_nreq", nr, 3);
    chk("miss_nstall", ns, 4);
    op(1, 0, 2'b10, 0, 32'h040, 0, 0, got, ns, nr);
    chk("hit_rdata", got, 32'hDEADBEEF);
    chk("hit_nreq", nr, 0);
    chk("hit_nstall", ns, 0);
    op(1, 0, 2'b00, 1, 32'h043, 0, 0, got, ns, nr);
    chk("lb_s", got, 32'hFFFFFFDE);
    op(1, 0, 2'b00, 0, 32'h043, 0, 0, got, ns, nr);
    chk("lb_u", got, 32'h000000DE);
    op(1, 0, 2'b01, 1, 32'h042, 0, 0, got, ns, nr);
    chk("lh_s", got, 32'hFFFFDEAD);
    op(0, 1, 2'b00, 0, 32'h041, 32'h00000055, 1, got, ns, nr);
    chk("sb_we", {31'b0, obs_we}, 32'd1);
    chk("sb_be", {28'b0, obs_be}, 32'h2);
    chk("sb_wdata", obs_wd, 32'h55555555);
    op(1, 0, 2'b10, 0, 32'h040, 0, 0, got, ns, nr);
    chk("merge_rdata", got, 32'hDEAD55EF);
    chk("merge_hit", nr, 0);
    op(0, 1, 2'b10, 0, 32'h080, 32'h12345678, 0, got, ns, nr);
    chk("sw_nreq", nr, 1);
    op(1, 0, 2'b10, 0, 32'h080, 0, 0, got, ns, nr);
    chk("noalloc_miss", nr, 1);
    chk("noalloc_data", got, 32'h12345678);

    // Reset abandons an outstanding miss.
    chk_en = 0;
    memread = 1; length = 2'b10; addr = 32'h0C0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("pre_rst_req", {31'b0, mem_req}, 32'd1);
    #1 rst = 1;
    #1;
    chk("rst_mid_req", {31'b0, mem_req}, 32'd0);
    chk("rst_mid_stall", {31'b0, stall}, 32'd0);
    chk("rst_mid_rdata", rdata, 32'd0);
    memread = 0;
    @(posedge clk); #1; rst = 0;
    for (int i = 0; i < 16; i++) mvalid[i] = 0;
    chk_en = 1;
    op(1, 0, 2'b10, 0, 32'h040, 0, 0, got, ns, nr);
    chk("post_rst_miss", nr, 1);

    for (int n = 0; n < 400; n++) begin
      int k;
      bit rd, wr;
      k = $urandom_range(0, 9);
      rd = (k >= 4);
      wr = (k >= 1 && k <= 4);
      r = $urandom();
      op(rd, wr, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
         {r[31:8], 8'($urandom())}, $urandom(), $urandom_range(0, 3), got, ns, nr);
    end

    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
